// File: rtl/led_arbiter.sv
// led_arbiter: owns the 4-bit LED bank; heartbeat when idle, round-robin
// loans of HOLD_TICKS prescaler ticks to two requesters via req/gnt/done.
//
// Ports:
//   pG0          clock (posedge)
//   pG1          synchronous active-high reset
//   req[1:0]     per-requester LED request
//   data0/data1  4-bit patterns, held stable while the matching req is high
//   leds[3:0]    LED pin drive (registered)
//   gnt[1:0]     one-cycle grant pulse (registered)
//   done         one-cycle end-of-slot pulse (registered)
//   busy         high while the LEDs are loaned out (registered)
//
// Optional feature: define LED_ARB_GAP_EN to blank the LEDs for up to one
// tick between a slot and the return to the heartbeat.
module led_arbiter #(
    parameter int PRESCALE_W = 10,
    parameter int HOLD_TICKS = 4
) (
    input  logic       pG0,
    input  logic       pG1,
    input  logic [1:0] req,
    input  logic [3:0] data0,
    input  logic [3:0] data1,
    output logic [3:0] leds,
    output logic [1:0] gnt,
    output logic       done,
    output logic       busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SHOW = 2'd1;
`ifdef LED_ARB_GAP_EN
    localparam logic [1:0] S_GAP  = 2'd2;
`endif
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_TICKS - 1);

    logic [PRESCALE_W-1:0] r_pre;
    logic [3:0]            r_hb;
    logic [1:0]            r_state;
    logic [7:0]            r_hold;
    logic [3:0]            r_pat;
    logic                  r_last;
    logic [3:0]            r_leds;
    logic [1:0]            r_gnt;
    logic                  r_done;
    logic                  r_busy;

    logic       w_tick;
    logic       w_win;
    logic [3:0] w_hb_nx;
    logic [1:0] w_state_nx;
    logic [7:0] w_hold_nx;
    logic [3:0] w_pat_nx;
    logic       w_last_nx;
    logic [1:0] w_gnt_nx;
    logic       w_done_nx;
    logic [3:0] w_leds_nx;

    assign w_tick  = &r_pre;
    assign w_hb_nx = w_tick ? r_hb + 4'd1 : r_hb;

    // Sole requester wins; on a tie the one that did not win last time.
    always_comb begin
        w_win = ~r_last;
        if (req == 2'b01) w_win = 1'b0;
        if (req == 2'b10) w_win = 1'b1;
    end

    always_comb begin
        w_state_nx = r_state;
        w_hold_nx  = r_hold;
        w_pat_nx   = r_pat;
        w_last_nx  = r_last;
        w_gnt_nx   = 2'b00;
        w_done_nx  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_state_nx = S_SHOW;
                    w_pat_nx   = w_win ? data1 : data0;
                    w_last_nx  = w_win;
                    w_hold_nx  = 8'd0;
                    w_gnt_nx   = w_win ? 2'b10 : 2'b01;
                end
            end
            S_SHOW: begin
                if (w_tick) begin
                    if (r_hold == HOLD_LAST) begin
                        w_done_nx  = 1'b1;
`ifdef LED_ARB_GAP_EN
                        w_state_nx = S_GAP;
`else
                        w_state_nx = S_IDLE;
`endif
                    end else begin
                        w_hold_nx = r_hold + 8'd1;
                    end
                end
            end
`ifdef LED_ARB_GAP_EN
            S_GAP: begin
                if (w_tick) w_state_nx = S_IDLE;
            end
`endif
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they line up
    // with the state they describe.
    always_comb begin
        w_leds_nx = 4'd0;
        if (w_state_nx == S_IDLE) w_leds_nx = w_hb_nx;
        if (w_state_nx == S_SHOW) w_leds_nx = w_pat_nx;
    end

    always_ff @(posedge pG0) begin
        if (pG1) begin
            r_pre   <= '0;
            r_hb    <= 4'd0;
            r_state <= S_IDLE;
            r_hold  <= 8'd0;
            r_pat   <= 4'd0;
            r_last  <= 1'b1;
            r_leds  <= 4'd0;
            r_gnt   <= 2'b00;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_pre   <= r_pre + PRESCALE_W'(1);
            r_hb    <= w_hb_nx;
            r_state <= w_state_nx;
            r_hold  <= w_hold_nx;
            r_pat   <= w_pat_nx;
            r_last  <= w_last_nx;
            r_leds  <= w_leds_nx;
            r_gnt   <= w_gnt_nx;
            r_done  <= w_done_nx;
            r_busy  <= (w_state_nx != S_IDLE);
        end
    end

    assign leds = r_leds;
    assign gnt  = r_gnt;
    assign done = r_done;
    assign busy = r_busy;

endmodule

// File: doc/led_arbiter.md
# led_arbiter

Owner and scheduler for the modboard's 4-bit LED pin bank. A prescaler produces a slow tick. When no one has claimed the LEDs, they show a free-running heartbeat count. Two requesters can each borrow the LEDs for a fixed number of ticks, granted round-robin through a req/gnt/done handshake. It sits between top-level pin logic (pG0 clock, LED pins) and any block that wants to display a 4-bit status.

## Interface
- PRESCALE_W, 10: prescaler width; one tick every 2^PRESCALE_W clocks.
- HOLD_TICKS, 4: ticks a granted requester keeps the LEDs; legal range 1..255.
- pG0  in  1  clock; all logic on posedge.
- pG1  in  1  reset, synchronous, active-high.
- req  in  2  request per requester; req[i] high requests the LEDs.
- data0  in  4  pattern from requester 0; must be stable while req[0] is high.
- data1  in  4  pattern from requester 1; must be stable while req[1] is high.
- leds  out  4  LED pin drive; the top level maps bit 3..0 onto p3A3..p3A0.
- gnt  out  2  one-cycle grant pulse; at most one bit set.
- done  out  1  one-cycle pulse when the current owner's slot ends.
- busy  out  1  high in SHOW and GAP.

## Operation
- Prescaler `pre` (PRESCALE_W bits) increments every clock and wraps. `tick` = (pre == all-ones), combinational.
- Heartbeat `hb` (4 bits) increments on every tick, in all states, and wraps 15->0.
- States:
  - IDLE: leds = hb.
  - SHOW: leds = the latched pattern `pat`.
  - GAP: leds = 0.
- IDLE->SHOW: taken on any clock with req != 0.
  - Winner: the only requester asserting req. If both assert, the one not equal to `last`.
  - Same edge: `pat` <= winner's data, `last` <= winner, hold counter <= 0, gnt[winner] = 1 for the following cycle only.
- SHOW: the hold counter (8 bits) increments on each tick.
  - On a tick with hold == HOLD_TICKS-1, leave SHOW: done = 1 the next cycle, next state GAP (or IDLE; see Configuration).
- GAP: return to IDLE on the next tick. done is not repeated.
- Requesters must drop req within the SHOW period. req still high when the FSM is in IDLE again counts as a new request. Round-robin then favours the other requester if both are high.
- req changes during SHOW or GAP are ignored; `pat` does not follow data changes.
- Reset, including mid-SHOW or mid-GAP: on the first edge with pG1 = 1, the following are cleared: state = IDLE, pre = 0, hb = 0, hold = 0, pat = 0, last = 1 (requester 0 wins the first tie).
- Outputs during and after reset: leds = 0, gnt = 0, done = 0, busy = 0. No done pulse is emitted for a slot aborted by reset.

## Timing
- Grant latency: req sampled high in IDLE at edge N -> gnt, busy and leds = pattern valid after edge N.
- SHOW length: ends at the HOLD_TICKS-th tick after entry. This is between (HOLD_TICKS-1)*2^PRESCALE_W+1 and HOLD_TICKS*2^PRESCALE_W clocks, depending on prescaler phase.
- done and the change to leds = 0 (GAP) appear on the same cycle.
- GAP lasts until the next tick, 1..2^PRESCALE_W clocks. Returning to IDLE restores leds = hb.
- Back-to-back service: at least one IDLE cycle separates two slots. gnt never pulses on consecutive cycles.
- All outputs are registered; no combinational path from req or data to leds, gnt or done.

## Configuration
- LED_ARB_GAP_EN defined: the GAP state exists as described.
- LED_ARB_GAP_EN undefined:
  - SHOW goes straight to IDLE on the final tick; done pulses on the first IDLE cycle.
  - leds show hb from that cycle, and busy is low in that cycle.
  - The GAP encoding and its logic are not synthesised.

## Test plan
Bench uses PRESCALE_W=2 and HOLD_TICKS=2.
- Reset then idle, no req for 64 clocks -> leds steps 0,1,2,… every 4 clocks; hb reaches 0 again at clock 64 (wrap); gnt, done and busy stay 0.
- req=01, data0=0xA, in IDLE -> gnt=01 one cycle; leds=0xA until the 2nd tick; done pulse with leds=0; then leds=hb after the next tick.
- req=11 raised together, data0=0x3, data1=0xC, both held high -> grants in order 0,1,0,1; leds show 0x3 and 0xC alternately with a GAP of 0 between them.
- data0 changed 0xA->0x5 during SHOW -> leds stay 0xA for the whole slot.
- pG1 pulsed for 1 clock mid-SHOW -> next cycle leds=0, busy=0, no done; a following req=10 is granted normally.
- Build without LED_ARB_GAP_EN, req=01 -> leds go directly from pattern to hb; leds are never 0 unless hb=0; done coincides with the first IDLE cycle.
